seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, registered, multi-cycle successor to the combinational ALU.
- Accepts one operation per valid/ready transaction on the input side and returns result and flags through a valid/ready output side.
- Single-cycle ops: ADD/SUB/logic/variable shifts. Iterative ops: restoring DIV/MOD, plus optional shift-add MUL.
- Sits between the register file read stage and the write-back stage; stalls upstream while busy.

Parameters:
- BITWIDTH, 8, operand/result width (>=4).
- SHAMTW, $clog2(BITWIDTH), derived; width of the shift count, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inValid  input  1  operation request valid.
- inReady  output  1  block can accept an operation; high only in IDLE.
- opA  input  BITWIDTH  operand A.
- opB  input  BITWIDTH  operand B, or shift amount for shifts.
- ALUop  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 ASR, 8 MUL, 9 DIV, 10 MOD; 11-15 illegal.
- outValid  output  1  result/flags valid.
- outReady  input  1  consumer accepts result.
- ALUout  output  BITWIDTH  result.
- zeroFlag  output  1  ALUout == 0.
- signFlag  output  1  ALUout[BITWIDTH-1].
- carryFlag  output  1  ADD carry-out; SUB borrow (opA < opB unsigned); 0 otherwise.
- overflowFlag  output  1  ADD/SUB signed overflow; MUL nonzero high half; 0 otherwise.
- divZeroFlag  output  1  DIV/MOD with opB == 0.
- illegalFlag  output  1  unsupported ALUop.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; outValid, ALUout and all flags 0; iteration counter 0.
  - inReady = (state==IDLE), so it reads 1 during reset.
- FSM:
  - IDLE: on inValid&&inReady, latch opA/opB/ALUop. Single-cycle or illegal op -> DONE. DIV/MOD/MUL -> BUSY.
  - BUSY: counter runs BITWIDTH cycles. Then result and flags are registered -> DONE.
  - DONE: outValid=1. ALUout and flags are held stable until outValid&&outReady, then -> IDLE.
- Latency, accept edge to outValid:
  - single-cycle/illegal: 1 cycle.
  - DIV/MOD/MUL: BITWIDTH+1 cycles.
  - Minimum throughput: 1 op per 2 cycles; no accept while in DONE.
- Input handling:
  - Inputs are ignored outside IDLE.
  - Latched operands are used for the whole iteration; input changes during BUSY have no effect.
- Arithmetic, all results truncated to BITWIDTH:
  - ADD/SUB computed at BITWIDTH+1 bits for carry.
  - Overflow: ADD = (A[msb]==B[msb]) && (R[msb]!=A[msb]); SUB = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
- Shifts use the full opB value:
  - opB >= BITWIDTH gives 0 for SHL/SHR and replicated sign for ASR.
  - opB == 0 passes opA through.
- DIV/MOD are unsigned restoring, one quotient bit per cycle.
  - opB == 0: no iteration. Go to DONE after 1 cycle with DIV result all-ones, MOD result opA, divZeroFlag=1.
- MUL: unsigned, low half in ALUout. overflowFlag=1 if the high half != 0.
- Illegal ALUop: ALUout=0, zeroFlag=1, illegalFlag=1, latency 1.
- Flags are computed from the final registered ALUout and change only on entry to DONE.
- rst_n asserted mid-BUSY or mid-DONE aborts the operation; the result is discarded with no partial output.

Optional Feature:
- Macro SEQ_ALU_MUL_EN.
- Defined: ALUop 8 performs an iterative shift-add MUL (BITWIDTH+1 latency, overflow on nonzero high half).
- Undefined: the multiplier datapath is not built, and ALUop 8 is treated as illegal (ALUout=0, illegalFlag=1, latency 1).

Test Plan (BITWIDTH=8):
- ADD 0x7F+0x01 -> ALUout 0x80, overflow 1, sign 1, carry 0, outValid 1 cycle after accept. Then ADD 0xFF+0x01 -> 0x00, zero 1, carry 1, overflow 0.
- SUB 0x00-0x01 -> 0xFF, carry(borrow) 1, sign 1, overflow 0. ASR 0x80 by 3 -> 0xF0. SHL 0x01 by 9 -> 0x00, zero 1.
- DIV 200/7 -> 28, then MOD 200/7 -> 4. Each has outValid exactly 9 cycles after accept, with inReady 0 throughout.
- DIV 0x55/0 -> 0xFF, divZero 1, latency 1. MOD 0x55/0 -> 0x55, divZero 1.
- With SEQ_ALU_MUL_EN: MUL 15*17 -> 255, overflow 0; MUL 16*16 -> 0x00, overflow 1, zero 1. Without the macro: MUL -> 0x00, illegal 1.
- Backpressure and reset:
  - Hold outReady=0 for 5 cycles in DONE -> ALUout/flags stable and inReady 0; accept on the cycle outReady=1.
  - Pulse rst_n low at cycle 4 of a DIV -> all outputs 0, IDLE, and no stale outValid afterward.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered multi-cycle ALU, valid/ready in and out.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier.
module seq_alu #(
  parameter int BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inValid,
  output logic                inReady,
  input  logic [BITWIDTH-1:0] opA,
  input  logic [BITWIDTH-1:0] opB,
  input  logic [3:0]          ALUop,
  output logic                outValid,
  input  logic                outReady,
  output logic [BITWIDTH-1:0] ALUout,
  output logic                zeroFlag,
  output logic                signFlag,
  output logic                carryFlag,
  output logic                overflowFlag,
  output logic                divZeroFlag,
  output logic                illegalFlag
);

  localparam int W = BITWIDTH;
  localparam int M = BITWIDTH - 1;
  localparam int SHAMTW = $clog2(BITWIDTH);

  localparam logic [W-1:0] BW_V = W'(BITWIDTH);
  localparam logic [SHAMTW-1:0] CNT_LAST = SHAMTW'(BITWIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MOD = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [SHAMTW-1:0] cnt_q;
  logic [W-1:0]      b_q;
  logic [3:0]        op_q;
  logic [W-1:0]      rem_q;
  logic [W-1:0]      quo_q;

  logic              vld_q;
  logic [W-1:0]      res_q;
  logic              zf_q;
  logic              sf_q;
  logic              cf_q;
  logic              vf_q;
  logic              dz_q;
  logic              il_q;

  logic [W:0]        sum_w;
  logic [W:0]        dif_w;
  logic              sh_big;
  logic [SHAMTW-1:0] shamt;
  logic [W-1:0]      s_res;
  logic              s_c;
  logic              s_v;
  logic              s_dz;
  logic              s_il;
  logic              s_iter;

  logic [W:0]        rem_sh;
  logic [W:0]        rem_df;
  logic              q_bit;
  logic [W-1:0]      rem_d;
  logic [W-1:0]      quo_d;
  logic [W-1:0]      b_res;
  logic              b_v;
`ifdef SEQ_ALU_MUL_EN
  logic [W:0]        mul_sum;
`endif

  logic [W-1:0]      res_d;
  logic              c_d;
  logic              v_d;
  logic              dz_d;
  logic              il_d;
  logic              load_out;

  assign inReady      = (state_q == S_IDLE);
  assign outValid     = vld_q;
  assign ALUout       = res_q;
  assign zeroFlag     = zf_q;
  assign signFlag     = sf_q;
  assign carryFlag    = cf_q;
  assign overflowFlag = vf_q;
  assign divZeroFlag  = dz_q;
  assign illegalFlag  = il_q;

  // Single-cycle result and op classification from the live inputs.
  always_comb begin
    sum_w  = {1'b0, opA} + {1'b0, opB};
    dif_w  = {1'b0, opA} - {1'b0, opB};
    sh_big = (opB >= BW_V);
    shamt  = opB[SHAMTW-1:0];
    s_res  = '0;
    s_c    = 1'b0;
    s_v    = 1'b0;
    s_dz   = 1'b0;
    s_il   = 1'b0;
    s_iter = 1'b0;
    case (ALUop)
      OP_ADD: begin
        s_res = sum_w[M:0];
        s_c   = sum_w[W];
        s_v   = (opA[M] == opB[M]) &&
                (sum_w[M] != opA[M]);
      end
      OP_SUB: begin
        s_res = dif_w[M:0];
        s_c   = dif_w[W];
        s_v   = (opA[M] != opB[M]) &&
                (dif_w[M] != opA[M]);
      end
      OP_AND: s_res = opA & opB;
      OP_OR:  s_res = opA | opB;
      OP_XOR: s_res = opA ^ opB;
      OP_SHL: s_res = sh_big ? '0 : (opA << shamt);
      OP_SHR: s_res = sh_big ? '0 : (opA >> shamt);
      OP_ASR: begin
        if (sh_big) s_res = {W{opA[M]}};
        else s_res = $unsigned($signed(opA) >>> shamt);
      end
      OP_MUL: begin
`ifdef SEQ_ALU_MUL_EN
        s_iter = 1'b1;
`else
        s_il = 1'b1;
`endif
      end
      OP_DIV: begin
        if (opB == '0) begin
          s_dz  = 1'b1;
          s_res = '1;
        end else begin
          s_iter = 1'b1;
        end
      end
      OP_MOD: begin
        if (opB == '0) begin
          s_dz  = 1'b1;
          s_res = opA;
        end else begin
          s_iter = 1'b1;
        end
      end
      default: s_il = 1'b1;
    endcase
  end

  // One iteration step: restoring divide or shift-add multiply.
  always_comb begin
    rem_sh = {rem_q, quo_q[M]};
    rem_df = rem_sh - {1'b0, b_q};
    q_bit  = ~rem_df[W];
    rem_d  = q_bit ? rem_df[M:0] : rem_sh[M:0];
    quo_d  = {quo_q[M-1:0], q_bit};
    b_res  = (op_q == OP_MOD) ? rem_d : quo_d;
    b_v    = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    mul_sum = {1'b0, rem_q} +
              (quo_q[0] ? {1'b0, b_q} : '0);
    if (op_q == OP_MUL) begin
      rem_d = mul_sum[W:1];
      quo_d = {mul_sum[0], quo_q[M:1]};
      b_res = quo_d;
      b_v   = |rem_d;
    end
`endif
  end

  // Select the value registered on entry to DONE.
  always_comb begin
    if (state_q == S_BUSY) begin
      res_d = b_res;
      c_d   = 1'b0;
      v_d   = b_v;
      dz_d  = 1'b0;
      il_d  = 1'b0;
    end else begin
      res_d = s_res;
      c_d   = s_c;
      v_d   = s_v;
      dz_d  = s_dz;
      il_d  = s_il;
    end
    load_out = ((state_q == S_IDLE) && inValid && !s_iter) ||
               ((state_q == S_BUSY) && (cnt_q == CNT_LAST));
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      cf_q    <= 1'b0;
      vf_q    <= 1'b0;
      dz_q    <= 1'b0;
      il_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (inValid) begin
            b_q   <= opB;
            op_q  <= ALUop;
            rem_q <= '0;
            quo_q <= opA;
            cnt_q <= '0;
            state_q <= s_iter ? S_BUSY : S_DONE;
          end
        end
        S_BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + SHAMTW'(1);
          if (cnt_q == CNT_LAST) state_q <= S_DONE;
        end
        S_DONE: begin
          if (outReady) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (load_out) begin
        vld_q <= 1'b1;
        res_q <= res_d;
        zf_q  <= ~|res_d;
        sf_q  <= res_d[M];
        cf_q  <= c_d;
        vf_q  <= v_d;
        dz_q  <= dz_d;
        il_q  <= il_d;
      end
    end
  end

endmodule
